// File: rtl/draw_rectangle_fill.sv
// draw_rectangle_fill
// Filled-rectangle rasteriser. It latches two opposite corners and orders
// them into (xa,ya)-(xb,yb). It then walks every pixel in raster order,
// emitting one pixel per cycle while oe is high.
//
// Ports
//   clk            system clock (only clock)
//   rst            synchronous, active-high reset; aborts any fill in progress
//   start          begin a fill; only looked at while idle
//   oe             output enable; the walk advances only when high
//   x0,y0,x1,y1    opposite corners, any order, CORDW-bit signed
//   x,y            current pixel (registered)
//   drawing        x/y is a valid pixel this cycle (DRAW && oe)
//   busy           high while ordering corners or drawing
//   done           one-cycle pulse after the last pixel
//
// x, y and drawing feed the bitmap-address / framebuffer-write path directly.
// That path applies its own write-enable delay, so no extra staging is added here.
module draw_rectangle_fill #(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t state, state_next;

    // corners as latched at start; later input changes are ignored
    logic signed [CORDW-1:0] lx0, ly0, lx1, ly1;
    // ordered bounds, valid from DRAW onwards
    logic signed [CORDW-1:0] xa, xb, ya, yb;

    logic last_pix;
    assign last_pix = (x == xb) && (y == yb);

    localparam logic [CORDW-1:0] ONE = {{(CORDW-1){1'b0}}, 1'b1};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = INIT;
            INIT: state_next = DRAW;
            DRAW: if (oe && last_pix) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // corner latch, ordering and raster walk
    always_ff @(posedge clk) begin
        if (rst) begin
            x   <= '0;
            y   <= '0;
            lx0 <= '0;
            ly0 <= '0;
            lx1 <= '0;
            ly1 <= '0;
            xa  <= '0;
            xb  <= '0;
            ya  <= '0;
            yb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lx0 <= x0;
                        ly0 <= y0;
                        lx1 <= x1;
                        ly1 <= y1;
                    end
                end
                INIT: begin
                    // x/y start at the min corner directly, so DRAW can emit
                    // on its first cycle without waiting for xa/ya to settle
                    xa <= (lx0 < lx1) ? lx0 : lx1;
                    xb <= (lx0 < lx1) ? lx1 : lx0;
                    ya <= (ly0 < ly1) ? ly0 : ly1;
                    yb <= (ly0 < ly1) ? ly1 : ly0;
                    x  <= (lx0 < lx1) ? lx0 : lx1;
                    y  <= (ly0 < ly1) ? ly0 : ly1;
                end
                DRAW: begin
                    // on the final pixel x/y hold; the FSM moves to DONE
                    if (oe && !last_pix) begin
                        if (x < xb) begin
                            x <= x + ONE;
                        end else begin
                            x <= xa;
                            y <= y + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign drawing = (state == DRAW) && oe;
    assign busy    = (state == INIT) || (state == DRAW);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_draw_rectangle_fill.sv
module tb_draw_rectangle_fill;

    localparam int CORDW = 16;

    logic clk = 1'b0;
    logic rst, start, oe;
    logic signed [CORDW-1:0] x0, y0, x1, y1;
    logic signed [CORDW-1:0] x, y;
    logic drawing, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_rectangle_fill #(.CORDW(CORDW)) dut (
        .clk(clk), .rst(rst), .start(start), .oe(oe),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int x0, y0, x1, y1;
        int oe_mode;    // 0: always on, 1: toggling 1,0,1,0, 2: random
        int exp_cnt;
        int fx, fy, lx, ly;
    } vec_t;

    // Run a full fill and compare the pixel stream with a reference list
    // built from the ordered bounds by nested loops.
    task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int oe_mode, input string tag,
                            output int cnt, output int fx, output int fy,
                            output int lx, output int ly, output int first_c);
        int xa, xb, ya, yb, c, last_c, done_c, ndone, budget, total;
        int qx[$];
        int qy[$];
        bit busy_bad, finished;
        xa = (ax0 < ax1) ? ax0 : ax1;
        xb = (ax0 < ax1) ? ax1 : ax0;
        ya = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        for (int yy = ya; yy <= yb; yy++)
            for (int xx = xa; xx <= xb; xx++) begin
                qx.push_back(xx);
                qy.push_back(yy);
            end
        total = qx.size();
        budget = 4 * total + 40;
        cnt = 0; fx = 0; fy = 0; lx = 0; ly = 0; first_c = -1;
        last_c = -1; done_c = -1; ndone = 0; busy_bad = 0; finished = 0;

        @(posedge clk); #1;
        x0 = ax0[CORDW-1:0]; y0 = ay0[CORDW-1:0];
        x1 = ax1[CORDW-1:0]; y1 = ay1[CORDW-1:0];
        start = 1'b1; oe = 1'b1;
        @(posedge clk); #1;
        // inputs change after latching; must not matter
        x0 = 16'($urandom_range(0, 500)); y0 = 16'($urandom_range(0, 500));
        x1 = 16'($urandom_range(0, 500)); y1 = 16'($urandom_range(0, 500));
        c = 1;
        while (c < budget) begin
            case (oe_mode)
                0: oe = 1'b1;
                1: oe = (c % 2 == 0);
                default: oe = ($urandom_range(0, 3) != 0);
            endcase
            start = (ndone == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (ndone > 0) begin
                chk({tag, " busy after done"}, int'(busy), 0);
                chk({tag, " done width"}, int'(done), 0);
                finished = 1;
                break;
            end
            if (!busy && !done) busy_bad = 1;
            if (drawing) begin
                cnt++;
                if (cnt == 1) begin
                    first_c = c; fx = int'(x); fy = int'(y);
                end
                lx = int'(x); ly = int'(y);
                if (qx.size() == 0) begin
                    chk({tag, " extra pixel"}, cnt, total);
                end else begin
                    if (int'(x) != qx[0] || int'(y) != qy[0]) begin
                        checks++; errors++;
                        $display("FAIL %s pixel %0d: got (%0d,%0d) expected (%0d,%0d)",
                                 tag, cnt, int'(x), int'(y), qx[0], qy[0]);
                    end else begin
                        checks++;
                    end
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    if (qx.size() == 0) last_c = c;
                end
            end
            if (done) begin
                ndone++;
                done_c = c;
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        if (!finished) chk({tag, " timeout"}, c, budget - 1);
        chk({tag, " pixel count"}, cnt, total);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " done after last pixel"}, done_c, last_c + 1);
        chk({tag, " busy dropped early"}, int'(busy_bad), 0);
    endtask

    vec_t vecs[5];
    int cnt, fx, fy, lx, ly, fc, n;

    initial begin
        vecs[0] = '{2, 3, 4, 5, 0, 9, 2, 3, 4, 5};
        vecs[1] = '{4, 5, 2, 3, 0, 9, 2, 3, 4, 5};
        vecs[2] = '{-3, 0, -1, -1, 0, 6, -3, -1, -1, 0};
        vecs[3] = '{7, 7, 7, 7, 0, 1, 7, 7, 7, 7};
        vecs[4] = '{0, 0, 9, 9, 1, 100, 0, 0, 9, 9};

        // reset, with start held high: reset must win
        rst = 1'b1; start = 1'b1; oe = 1'b1;
        x0 = 16'sd5; y0 = 16'sd5; x1 = 16'sd6; y1 = 16'sd6;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset drawing", int'(drawing), 0);
        chk("reset x", int'(x), 0);
        chk("reset y", int'(y), 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle without start", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_fill(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].oe_mode,
                     tag, cnt, fx, fy, lx, ly, fc);
            chk({tag, " table count"}, cnt, vecs[i].exp_cnt);
            chk({tag, " first x"}, fx, vecs[i].fx);
            chk({tag, " first y"}, fy, vecs[i].fy);
            chk({tag, " last x"}, lx, vecs[i].lx);
            chk({tag, " last y"}, ly, vecs[i].ly);
            if (vecs[i].oe_mode == 0) chk({tag, " first draw latency"}, fc, 2);
        end

        // reset on the 5th drawing cycle of a 10x10 fill
        @(posedge clk); #1;
        x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd9; y1 = 16'sd9;
        start = 1'b1; oe = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (drawing) n++;
            if (n == 5) break;
            @(posedge clk); #1;
        end
        chk("abort reached 5th pixel", n, 5);
        chk("abort 5th pixel x", int'(x), 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort x", int'(x), 0);
        chk("abort y", int'(y), 0);
        chk("abort drawing", int'(drawing), 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        chk("abort no done/busy afterwards", n, 0);
        run_fill(0, 0, 9, 9, 0, "refill", cnt, fx, fy, lx, ly, fc);
        chk("refill count", cnt, 100);

        // random rectangles, including negative coordinates
        for (int i = 0; i < 20; i++) begin
            int rx0, ry0, rx1, ry1;
            rx0 = int'($urandom_range(0, 40)) - 20;
            ry0 = int'($urandom_range(0, 40)) - 20;
            rx1 = rx0 + int'($urandom_range(0, 12)) - 6;
            ry1 = ry0 + int'($urandom_range(0, 12)) - 6;
            run_fill(rx0, ry0, rx1, ry1, 2, $sformatf("rnd%0d", i),
                     cnt, fx, fy, lx, ly, fc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_rectangle_fill.md
DRAW_RECTANGLE_FILL -- requirements
Module: draw_rectangle_fill

Interface
REQ-001 SHALL have parameter CORDW, default 16, signed coordinate width in bits.
REQ-002 SHALL have port clk, input, 1, system clock; this is the block's only clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin drawing, sampled only in IDLE.
REQ-005 SHALL have port oe, input, 1, output enable; draws one pixel per cycle while high.
REQ-006 SHALL have ports x0, y0, x1, y1, input, CORDW signed, opposite corners of the rectangle, in any order.
REQ-007 SHALL have ports x, y, output, CORDW signed, current pixel coordinate.
REQ-008 SHALL have port drawing, output, 1, x/y hold a valid pixel this cycle.
REQ-009 SHALL have port busy, output, 1, fill in progress.
REQ-010 SHALL have port done, output, 1, single-cycle pulse on completion.

Function
REQ-011 SHALL implement the states IDLE, INIT, DRAW and DONE.
REQ-012 IDLE with start=1 SHALL latch x0/y0/x1/y1 and go to INIT next cycle; start=0 SHALL stay in IDLE.
REQ-013 INIT SHALL order the corners into xa=min(x0,x1), xb=max(x0,x1), ya=min(y0,y1), yb=max(y0,y1), using signed compares, then set x=xa, y=ya and go to DRAW; INIT lasts exactly one cycle.
REQ-014 drawing SHALL be combinational and equal (state==DRAW && oe); x/y SHALL be registered.
REQ-015 DRAW with oe=1 SHALL step in raster order: if x<xb then x<=x+1; else x<=xa, y<=y+1.
REQ-016 DRAW with oe=1 at x==xb && y==yb SHALL go to DONE next cycle and SHALL hold x/y.
REQ-017 DRAW with oe=0 SHALL hold state, x and y; no pixel is emitted.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-019 busy SHALL be high in INIT and DRAW, and low in IDLE and DONE.
REQ-020 start while not in IDLE SHALL be ignored, and coordinate input changes after latching SHALL have no effect.
REQ-021 A degenerate rectangle (x0==x1 and/or y0==y1) SHALL draw a single column, row or pixel; a 1x1 rectangle emits exactly one drawing cycle.
REQ-022 Pixel count SHALL equal (xb-xa+1)*(yb-ya+1); each pixel is emitted exactly once, with no gaps or repeats.
REQ-023 Internal compares and increments SHALL use CORDW-bit signed arithmetic; callers keep coordinates within ±(2^(CORDW-1)-2), so x+1 never overflows.
REQ-024 The first drawing cycle SHALL be at the earliest 2 cycles after the start cycle (IDLE->INIT->DRAW).

Reset
REQ-025 rst=1 SHALL, on the next clk edge, force IDLE and set x=0, y=0, busy=0, done=0; drawing is therefore 0.
REQ-026 rst during INIT, DRAW or DONE SHALL abort the fill immediately, with no done pulse.
REQ-027 rst SHALL take priority over start on the same cycle.

Structure
REQ-028 The state type SHALL be local to the module; no shared-package typedefs or constants are required, and CORDW is passed by parameter.
REQ-029 The module SHALL contain no sub-modules; it is a single FSM plus coordinate registers.
REQ-030 The outputs x, y and drawing SHALL connect directly to the existing bitmap-address and framebuffer-write path, which applies its own 2-cycle write-enable delay.

Verification
REQ-031 Corners (2,3),(4,5), oe=1 constant -> 9 drawing cycles in order (2,3),(3,3),(4,3),(2,4)...(4,5); done 1 cycle after last pixel; busy low thereafter.
REQ-032 Reversed corners (4,5),(2,3) -> output sequence identical to REQ-031.
REQ-033 Corners (-3,0),(-1,-1) -> xa=-3, ya=-1; pixels (-3,-1),(-2,-1),(-1,-1),(-3,0),(-2,0),(-1,0); 6 drawing cycles.
REQ-034 Corners (7,7),(7,7) -> exactly one drawing cycle at (7,7), then a done pulse.
REQ-035 Corners (0,0),(9,9) with oe toggling 1,0,1,0 -> 100 drawing cycles total; x/y held during oe=0; start pulses during busy ignored.
REQ-036 rst asserted on the 5th drawing cycle of (0,0),(9,9) -> next cycle IDLE, x=y=0, busy=0, no done; a new start afterwards draws the full rectangle again.
